// File: rtl/bcd_count_src.sv
// bcd_count_src
//   Two-digit BCD value source for the seven-segment display path.
//   A prescaler divides clk down to a step tick. On each step the digit pair
//   counts 00..99 up or down and wraps at either end. The block also supports
//   a parallel load (saturating each nibble to 9) and a hold control.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous active-high reset
//   en        in   1  1 = prescaler runs and counting allowed, 0 = hold
//   up_dn     in   1  1 = count up, 0 = count down (used on step cycles only)
//   load      in   1  one-cycle request to load load_val
//   load_val  in   8  {tens, ones} BCD value to load
//   tens      out  4  BCD tens digit 0..9
//   ones      out  4  BCD ones digit 0..9
//   tick      out  1  one-cycle pulse coincident with freshly stepped digits
//   wrap      out  1  one-cycle pulse with tick when the step wrapped 99<->00
module bcd_count_src #(
  parameter int TICK_DIV = 1000000,
  parameter int PRE_W    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       tick,
  output logic       wrap
);

  localparam logic [PRE_W-1:0] LP_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_tick;
  logic             r_wrap;

  logic             w_step;
  logic [3:0]       w_tens_nx;
  logic [3:0]       w_ones_nx;
  logic             w_wrap_nx;

  // Clamp a loaded nibble into the BCD range so no illegal digit can enter.
  function automatic logic [3:0] sat_bcd(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  assign w_step = en & (r_pre == LP_LAST);

  // Next digit pair for a step in the requested direction.
  always_comb begin
    w_tens_nx = r_tens;
    w_ones_nx = r_ones;
    w_wrap_nx = 1'b0;
    if (up_dn) begin
      if (r_ones != 4'd9) begin
        w_ones_nx = r_ones + 4'd1;
      end else begin
        w_ones_nx = 4'd0;
        if (r_tens != 4'd9) begin
          w_tens_nx = r_tens + 4'd1;
        end else begin
          w_tens_nx = 4'd0;
          w_wrap_nx = 1'b1;
        end
      end
    end else begin
      if (r_ones != 4'd0) begin
        w_ones_nx = r_ones - 4'd1;
      end else begin
        w_ones_nx = 4'd9;
        if (r_tens != 4'd0) begin
          w_tens_nx = r_tens - 4'd1;
        end else begin
          w_tens_nx = 4'd9;
          w_wrap_nx = 1'b1;
        end
      end
    end
  end

  // Priority: reset, then load, then step; otherwise the prescaler advances
  // only while enabled and holds its value when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_tens <= 4'd0;
      r_ones <= 4'd0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_pre  <= '0;
      r_tens <= sat_bcd(load_val[7:4]);
      r_ones <= sat_bcd(load_val[3:0]);
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_step) begin
      r_pre  <= '0;
      r_tens <= w_tens_nx;
      r_ones <= w_ones_nx;
      r_tick <= 1'b1;
      r_wrap <= w_wrap_nx;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (en) begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_bcd_count_src.sv
module tb_bcd_count_src;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tick;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  // Expected {tens, ones, wrap} for each tick the DUT should produce.
  logic [8:0] exp_q[$];

  bcd_count_src #(
    .TICK_DIV(4),
    .PRE_W   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up_dn   (up_dn),
    .load    (load),
    .load_val(load_val),
    .tens    (tens),
    .ones    (ones),
    .tick    (tick),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every tick pops one expected value.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_tick: got tens=%0d ones=%0d wrap=%b, expected no tick",
                 tens, ones, wrap);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({tens, ones, wrap} !== e) begin
          bad++;
          $display("FAIL sb_step: got tens=%0d ones=%0d wrap=%b, expected tens=%0d ones=%0d wrap=%b",
                   tens, ones, wrap, e[8:5], e[4:1], e[0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int t, input int o, input logic w);
    exp_q.push_back({4'(t), 4'(o), w});
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    cyc();
    load     = 1'b0;
  endtask

  task automatic chk_tick(input string nm, input logic e);
    total++;
    if (tick !== e) begin
      bad++;
      $display("FAIL %s: tick got %b expected %b", nm, tick, e);
    end
  endtask

  task automatic chk_val(input string nm, input logic [3:0] et, input logic [3:0] eo,
                         input logic et_k, input logic ew);
    total++;
    if ({tens, ones, tick, wrap} !== {et, eo, et_k, ew}) begin
      bad++;
      $display("FAIL %s: got tens=%0d ones=%0d tick=%b wrap=%b, expected tens=%0d ones=%0d tick=%b wrap=%b",
               nm, tens, ones, tick, wrap, et, eo, et_k, ew);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
    cyc();
    cyc();
    rst = 1'b0;
    chk_val("reset_state", 4'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk_val("reset_hold", 4'd0, 4'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_count_up();
    for (int k = 1; k <= 10; k++) push_exp(k / 10, k % 10, 1'b0);
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      chk_tick("up_tick_period", (i % 4) == 0);
    end
    chk_val("up_after_10", 4'd1, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap_up();
    up_dn = 1'b1; en = 1'b1;
    do_load(8'h98);
    chk_val("load_98", 4'd9, 4'd8, 1'b0, 1'b0);
    push_exp(9, 9, 1'b0);
    push_exp(0, 0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk_tick("wrap_up_tick", (i % 4) == 0);
    end
    chk_val("wrap_up_00", 4'd0, 4'd0, 1'b1, 1'b1);
    cyc();
    chk_val("wrap_up_pulse_end", 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_down();
    up_dn = 1'b0; en = 1'b1;
    do_load(8'h00);
    chk_val("load_00", 4'd0, 4'd0, 1'b0, 1'b0);
    push_exp(9, 9, 1'b1);
    push_exp(9, 8, 1'b0);
    for (int i = 1; i <= 4; i++) cyc();
    chk_val("down_wrap_99", 4'd9, 4'd9, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) cyc();
    chk_val("down_98", 4'd9, 4'd8, 1'b1, 1'b0);
  endtask

  task automatic test_load();
    en = 1'b0;
    do_load(8'h37);
    chk_val("load_en_off", 4'd3, 4'd7, 1'b0, 1'b0);
    en = 1'b1;
    do_load(8'hAF);
    chk_val("load_saturate", 4'd9, 4'd9, 1'b0, 1'b0);
    cyc(); cyc(); cyc();
    // prescaler is now at its last count: this edge would be a step
    do_load(8'h45);
    chk_val("load_beats_step", 4'd4, 4'd5, 1'b0, 1'b0);
    up_dn = 1'b1;
    push_exp(4, 6, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk_tick("after_load_tick", i == 4);
    end
    chk_val("after_load_46", 4'd4, 4'd6, 1'b1, 1'b0);
  endtask

  task automatic test_en_hold();
    cyc(); cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_val("hold_en_off", 4'd4, 4'd6, 1'b0, 1'b0);
    end
    en = 1'b1;
    push_exp(4, 7, 1'b0);
    cyc();
    chk_tick("resume_pre3", 1'b0);
    cyc();
    chk_val("resume_step", 4'd4, 4'd7, 1'b1, 1'b0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_val("rst_mid_prescale", 4'd0, 4'd0, 1'b0, 1'b0);
    push_exp(0, 1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk_tick("post_rst_tick", i == 4);
    end
    chk_val("post_rst_01", 4'd0, 4'd1, 1'b1, 1'b0);
    en = 1'b0;
    cyc(); cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expected ticks never seen, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_load();
    test_en_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
